// File: rtl/stage_mem.sv
// Memory stage of the 5-stage MIPS pipeline: byte/half/word load-store against a
// word-addressed data memory, with all write-back and PC-select signals registered.
module stage_mem #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic        use_npc,
    input  logic [31:0] jump_address,
    input  logic        control_mem_read,
    input  logic        control_mem_write,
    input  logic [1:0]  control_mem_size,
    input  logic        control_mem_unsigned,
    input  logic        control_reg_write,
    input  logic [4:0]  dest_reg,
    output logic [31:0] mem_data,
    output logic [31:0] alu_result,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_dest_reg,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        misaligned
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [0:DEPTH-1];
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 is_word;
    logic                 is_half;
    logic                 access;
    logic                 bad_align;
    logic [31:0]          rd_word;
    logic [31:0]          wr_word;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [31:0]          ld_val;

    assign word_idx  = alu_out[ADDR_BITS+1:2];
    assign lane      = alu_out[1:0];
    assign is_word   = control_mem_size[1];
    assign is_half   = (control_mem_size == 2'b01);
    assign access    = control_mem_read | control_mem_write;
    assign bad_align = access & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));

    // Read happens before the edge, so a same-cycle store never affects the loaded value.
    assign rd_word = mem[word_idx];

    always_comb begin
        ld_byte = rd_word[{lane, 3'b000} +: 8];
        ld_half = rd_word[{lane[1], 4'b0000} +: 16];
        if (is_word) begin
            ld_val = rd_word;
        end else if (is_half) begin
            ld_val = {{16{~control_mem_unsigned & ld_half[15]}}, ld_half};
        end else begin
            ld_val = {{24{~control_mem_unsigned & ld_byte[7]}}, ld_byte};
        end
    end

    always_comb begin
        wr_word = rd_word;
        if (is_word) begin
            wr_word = store_data;
        end else if (is_half) begin
            wr_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
        end else begin
            wr_word[{lane, 3'b000} +: 8] = store_data[7:0];
        end
    end

    // Memory contents survive reset; reset only suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && control_mem_write && !bad_align) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_data      <= 32'd0;
            alu_result    <= 32'd0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_dest_reg   <= 5'd0;
            branch_taken  <= 1'b0;
            branch_target <= 32'd0;
            misaligned    <= 1'b0;
        end else begin
            alu_result    <= alu_out;
            wb_dest_reg   <= dest_reg;
            branch_taken  <= ~use_npc;
            branch_target <= jump_address;
            misaligned    <= bad_align;
            wb_reg_write  <= control_reg_write & ~bad_align;
            wb_mem_to_reg <= control_mem_read & ~control_mem_write;
            if (bad_align) begin
                mem_data <= 32'd0;
            end else if (control_mem_read) begin
                mem_data <= ld_val;
            end
        end
    end
endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios followed by random traffic, all compared
// against a byte-array reference model of the data memory.
module tb_stage_mem;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alu_out, store_data, jump_address;
    logic        use_npc, control_mem_read, control_mem_write;
    logic [1:0]  control_mem_size;
    logic        control_mem_unsigned, control_reg_write;
    logic [4:0]  dest_reg;
    logic [31:0] mem_data, alu_result, branch_target;
    logic        wb_reg_write, wb_mem_to_reg, branch_taken, misaligned;
    logic [4:0]  wb_dest_reg;

    always #5 clock = ~clock;

    stage_mem #(.ADDR_BITS(8)) dut (
        .clock(clock), .reset(reset), .alu_out(alu_out), .store_data(store_data),
        .use_npc(use_npc), .jump_address(jump_address),
        .control_mem_read(control_mem_read), .control_mem_write(control_mem_write),
        .control_mem_size(control_mem_size), .control_mem_unsigned(control_mem_unsigned),
        .control_reg_write(control_reg_write), .dest_reg(dest_reg),
        .mem_data(mem_data), .alu_result(alu_result), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dest_reg(wb_dest_reg),
        .branch_taken(branch_taken), .branch_target(branch_target), .misaligned(misaligned)
    );

    int errors = 0;
    int checks = 0;

    // Reference: 256 words = 1024 bytes, little-endian, byte address = alu_out mod 1024.
    logic [7:0]  ref_bytes [1024];
    logic [31:0] exp_md = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        int base, h;
        logic [7:0]  b;
        logic [15:0] hv;
        base = int'(a[9:0]) & 'h3FC;
        if (sz == 2'b00) begin
            b = ref_bytes[base + int'(a[1:0])];
            return uns ? {24'd0, b} : {{24{b[7]}}, b};
        end else if (sz == 2'b01) begin
            h  = base + (a[1] ? 2 : 0);
            hv = {ref_bytes[h+1], ref_bytes[h]};
            return uns ? {16'd0, hv} : {{16{hv[15]}}, hv};
        end
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int base, h;
        base = int'(a[9:0]) & 'h3FC;
        if (sz == 2'b00) begin
            ref_bytes[base + int'(a[1:0])] = d[7:0];
        end else if (sz == 2'b01) begin
            h = base + (a[1] ? 2 : 0);
            ref_bytes[h]   = d[7:0];
            ref_bytes[h+1] = d[15:8];
        end else begin
            for (int i = 0; i < 4; i++) ref_bytes[base+i] = d[8*i +: 8];
        end
    endtask

    // One pipeline cycle: predict outputs from the model, apply inputs, clock, compare.
    task automatic run(input logic rst, input logic [31:0] a, input logic [31:0] sd,
                       input logic npc, input logic [31:0] ja, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns, input logic rw, input logic [4:0] dr);
        logic        bad, skip_md;
        logic [31:0] e_alu, e_bt;
        logic        e_rw, e_m2r, e_bk, e_mis;
        logic [4:0]  e_dr;
        bad = (rd || wr) && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
        skip_md = 1'b0;
        if (rst) begin
            exp_md = 0; e_alu = 0; e_bt = 0; e_rw = 0; e_m2r = 0; e_bk = 0; e_mis = 0; e_dr = 0;
        end else begin
            if (bad) exp_md = 32'd0;
            else if (rd) exp_md = model_load(a, sz, uns);
            else if (wr) skip_md = 1'b1;
            if (wr && !bad) model_store(a, sz, sd);
            e_alu = a; e_bt = ja; e_dr = dr; e_bk = !npc; e_mis = bad;
            e_rw = rw && !bad; e_m2r = rd && !wr;
        end
        reset = rst; alu_out = a; store_data = sd; use_npc = npc; jump_address = ja;
        control_mem_read = rd; control_mem_write = wr; control_mem_size = sz;
        control_mem_unsigned = uns; control_reg_write = rw; dest_reg = dr;
        @(posedge clock);
        #1;
        if (!skip_md) check("mem_data", mem_data, exp_md);
        check("alu_result", alu_result, e_alu);
        check("wb_reg_write", 32'(wb_reg_write), 32'(e_rw));
        check("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e_m2r));
        check("wb_dest_reg", 32'(wb_dest_reg), 32'(e_dr));
        check("branch_taken", 32'(branch_taken), 32'(e_bk));
        check("branch_target", branch_target, e_bt);
        check("misaligned", 32'(misaligned), 32'(e_mis));
    endtask

    initial begin
        logic [31:0] w10;
        logic [31:0] ra;
        logic [1:0]  rsz;
        logic        rrd, rwr;

        run(1, 0, 0, 1, 0, 0, 0, 2'b10, 0, 0, 0);
        for (int i = 0; i < 256; i++) run(0, 32'(i*4), $urandom, 1, 0, 0, 1, 2'b10, 0, 0, 0);

        // Reset with a pending store: outputs cleared, store cancelled.
        w10 = model_load(32'h10, 2'b10, 0);
        run(1, 32'h10, 32'hDEADBEEF, 0, 32'h55, 0, 1, 2'b10, 0, 1, 3);
        run(1, 32'h10, 32'hDEADBEEF, 0, 32'h55, 0, 1, 2'b10, 0, 1, 3);
        check("reset_branch_taken", 32'(branch_taken), 32'd0);
        run(0, 32'h10, 0, 1, 0, 1, 0, 2'b10, 0, 1, 2);
        check("reset_store_cancelled", mem_data, w10);
        run(0, 32'h10, 32'hDEADBEEF, 0, 32'h55, 0, 1, 2'b10, 0, 1, 3);
        check("post_reset_branch_taken", 32'(branch_taken), 32'd1);

        // Byte-lane read-modify-write.
        run(0, 32'h20, 32'h8899AABB, 1, 0, 0, 1, 2'b10, 0, 0, 0);
        run(0, 32'h21, 32'h00000011, 1, 0, 0, 1, 2'b00, 0, 0, 0);
        run(0, 32'h20, 0, 1, 0, 1, 0, 2'b10, 0, 1, 7);
        check("sb_merge_data", mem_data, 32'h889911BB);
        check("lw_mem_to_reg", 32'(wb_mem_to_reg), 32'd1);
        check("lw_reg_write", 32'(wb_reg_write), 32'd1);

        // Sign/zero extension.
        run(0, 32'h40, 32'h000080F0, 1, 0, 0, 1, 2'b10, 0, 0, 0);
        run(0, 32'h40, 0, 1, 0, 1, 0, 2'b00, 0, 1, 1);
        check("lb", mem_data, 32'hFFFFFFF0);
        run(0, 32'h40, 0, 1, 0, 1, 0, 2'b00, 1, 1, 1);
        check("lbu", mem_data, 32'h000000F0);
        run(0, 32'h40, 0, 1, 0, 1, 0, 2'b01, 0, 1, 1);
        check("lh", mem_data, 32'hFFFF80F0);
        run(0, 32'h40, 0, 1, 0, 1, 0, 2'b01, 1, 1, 1);
        check("lhu", mem_data, 32'h000080F0);

        // Misaligned accesses.
        run(0, 32'h41, 32'h0000BEEF, 1, 0, 0, 1, 2'b01, 0, 1, 4);
        check("sh_misaligned", 32'(misaligned), 32'd1);
        check("sh_misaligned_rw", 32'(wb_reg_write), 32'd0);
        run(0, 32'h42, 0, 1, 0, 1, 0, 2'b10, 0, 1, 4);
        check("lw_misaligned", 32'(misaligned), 32'd1);
        check("lw_misaligned_data", mem_data, 32'd0);
        run(0, 32'h40, 0, 1, 0, 1, 0, 2'b10, 0, 1, 4);
        check("aligned_after_mis", 32'(misaligned), 32'd0);
        check("mem_unchanged_after_mis", mem_data, 32'h000080F0);

        // Address wrap.
        run(0, 32'h400, 32'hCAFEBABE, 1, 0, 0, 1, 2'b10, 0, 0, 0);
        run(0, 32'h000, 0, 1, 0, 1, 0, 2'b10, 0, 1, 9);
        check("wrap", mem_data, 32'hCAFEBABE);

        // Plain ALU op.
        run(0, 32'h1234, 0, 1, 32'h80, 0, 0, 2'b10, 0, 1, 5);
        check("alu_pass", alu_result, 32'h1234);
        check("alu_dest", 32'(wb_dest_reg), 32'd5);
        check("alu_m2r", 32'(wb_mem_to_reg), 32'd0);
        check("alu_bt", branch_target, 32'h80);

        // Read+write together: store happens, pre-store contents loaded.
        run(0, 32'h80, 32'h11223344, 1, 0, 0, 1, 2'b10, 0, 0, 0);
        run(0, 32'h80, 32'h000000AA, 1, 0, 1, 1, 2'b00, 1, 1, 6);
        check("rw_prestore", mem_data, 32'h00000044);
        check("rw_m2r", 32'(wb_mem_to_reg), 32'd0);
        run(0, 32'h80, 0, 1, 0, 1, 0, 2'b10, 0, 1, 6);
        check("rw_stored", mem_data, 32'h112233AA);

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            ra  = $urandom;
            rsz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) ra[1:0] = rsz[1] ? 2'b00 : (rsz == 2'b01 ? {ra[1], 1'b0} : ra[1:0]);
            rrd = 1'($urandom_range(0, 1));
            rwr = 1'($urandom_range(0, 1));
            run($urandom_range(0, 39) == 0, ra, $urandom, 1'($urandom_range(0, 1)), $urandom,
                rrd, rwr, rsz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
